btop_seq: RTL and testbench

BTOP_SEQ -- requirements
Module: btop_seq

---
 rtl/btop_seq.sv | 162 ++++++++++++++++
 tb/tb_btop_seq.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/btop_seq.sv
// btop_seq -- fill/drain sequencer for beta blocks held in an external
// slot storage.
//
// One start pulse opens a pass of num+1 slots. Upstream blocks are written
// to slots 0..num in order while the sequencer is filling. Downstream may
// read back a slot as soon as it is written, and reads continue into the
// drain phase until slot num has been read. Storage returns read data one
// cycle after the read enable. rd_data is passed straight through and
// qualified by rd_valid.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   start, blk_num        pass start pulse and slot count minus one
//   wr_valid/wr_ready     upstream block handshake, wr_data = block
//   rd_req/rd_gnt         downstream read request and grant
//   rd_data/rd_valid      read data returned to downstream
//   ram_b_in/ram_cnta/ram_w_en   storage write port
//   ram_cntb/ram_r_en/ram_b_out  storage read port (1-cycle latency)
//   busy, done            status: not idle, one-cycle completion pulse
//   dbg_state             current FSM state, for observation only
//
// Handshake rule: a transfer happens in a cycle where valid (or req) and
// ready (or gnt) are both high at the rising edge. valid/req may be raised
// or dropped freely; ready and gnt are combinational and only ever depend
// on the current state, the registered counters and the request itself.

module btop_seq #(
    parameter int P  = 64,
    parameter int Q  = 6,
    parameter int CW = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CW-1:0]    blk_num,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [2*P*Q-1:0] wr_data,
    input  logic             rd_req,
    output logic             rd_gnt,
    output logic [P*Q-1:0]   rd_data,
    output logic             rd_valid,
    output logic [2*P*Q-1:0] ram_b_in,
    output logic [CW-1:0]    ram_cnta,
    output logic             ram_w_en,
    output logic [CW-1:0]    ram_cntb,
    output logic             ram_r_en,
    input  logic [P*Q-1:0]   ram_b_out,
    output logic             busy,
    output logic             done,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] num_q, num_d;
    logic [CW:0]   wr_cnt_q, wr_cnt_d;
    logic [CW:0]   rd_cnt_q, rd_cnt_d;
    logic          rd_valid_q;
    logic          busy_q;
    logic          done_q;

    logic          wr_fire;
    logic          rd_fire;
    logic [CW:0]   num_ext;

    assign num_ext = {1'b0, num_q};

    // Counters are one bit wider than the slot index so that "num+1 slots
    // written" is representable without wrapping back to slot 0.
    always_comb begin
        state_d  = state_q;
        num_d    = num_q;
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;

        wr_ready = (state_q == FILL);
        wr_fire  = wr_valid && wr_ready;

        // Reads compare against the registered write count, so a slot being
        // written this cycle only becomes readable on the next one.
        rd_fire  = ((state_q == FILL) || (state_q == DRAIN)) && rd_req &&
                   (rd_cnt_q < wr_cnt_q) && (rd_cnt_q <= num_ext);

        case (state_q)
            IDLE: begin
                if (start) begin
                    num_d    = blk_num;
                    wr_cnt_d = '0;
                    rd_cnt_d = '0;
                    state_d  = FILL;
                end
            end
            FILL: begin
                if (wr_fire) begin
                    wr_cnt_d = wr_cnt_q + 1'b1;
                    if (wr_cnt_q == num_ext) begin
                        state_d = DRAIN;
                    end
                end
                if (rd_fire) begin
                    rd_cnt_d = rd_cnt_q + 1'b1;
                end
            end
            DRAIN: begin
                if (rd_fire) begin
                    rd_cnt_d = rd_cnt_q + 1'b1;
                    if (rd_cnt_q == num_ext) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            num_q      <= '0;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            rd_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            num_q      <= num_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            rd_valid_q <= rd_fire;
            // Status flags track the state being entered, so they are plain
            // flops that line up exactly with state_q.
            busy_q     <= (state_d != IDLE);
            done_q     <= (state_d == DONE);
        end
    end

    assign ram_w_en  = wr_fire;
    assign ram_cnta  = wr_cnt_q[CW-1:0];
    assign ram_b_in  = wr_data;
    assign rd_gnt    = rd_fire;
    assign ram_r_en  = rd_fire;
    assign ram_cntb  = rd_cnt_q[CW-1:0];
    assign rd_valid  = rd_valid_q;
    assign rd_data   = ram_b_out;
    assign busy      = busy_q;
    assign done      = done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_btop_seq.sv
module tb_btop_seq;

  localparam int P  = 4;
  localparam int Q  = 3;
  localparam int CW = 4;
  localparam int HW = P * Q;
  localparam int DW = 2 * P * Q;
  localparam int NB = 1 << CW;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start = 1'b0;
  logic [CW-1:0] blk_num = '0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [DW-1:0] wr_data = '0;
  logic          rd_req = 1'b0;
  logic          rd_gnt;
  logic [HW-1:0] rd_data;
  logic          rd_valid;
  logic [DW-1:0] ram_b_in;
  logic [CW-1:0] ram_cnta;
  logic          ram_w_en;
  logic [CW-1:0] ram_cntb;
  logic          ram_r_en;
  logic [HW-1:0] ram_b_out;
  logic          busy;
  logic          done;
  logic [1:0]    dbg_state;

  btop_seq #(.P(P), .Q(Q), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .blk_num(blk_num),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_req(rd_req), .rd_gnt(rd_gnt), .rd_data(rd_data), .rd_valid(rd_valid),
    .ram_b_in(ram_b_in), .ram_cnta(ram_cnta), .ram_w_en(ram_w_en),
    .ram_cntb(ram_cntb), .ram_r_en(ram_r_en), .ram_b_out(ram_b_out),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // storage model: full block stored per slot, lower half returned on read
  logic [DW-1:0] mem [NB];
  always @(posedge clk) begin
    if (ram_w_en) mem[ram_cnta] <= ram_b_in;
    if (ram_r_en) ram_b_out <= mem[ram_cntb][HW-1:0];
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ctl_vec();
    return {20'd0, busy, done, wr_ready, rd_gnt, ram_w_en, ram_r_en, rd_valid,
            ram_cnta, ram_cntb} ;
  endfunction

  // scoreboard queue: lower halves of accepted blocks, in slot order
  logic [HW-1:0] exp_q[$];

  // reference model: a pass of m_n+1 slots, counted writes and reads
  bit m_active = 0;
  bit m_done = 0;
  bit m_pg = 0;
  int m_n = 0;
  int m_wr = 0;
  int m_rd = 0;

  always @(negedge clk) begin
    bit e_rdy, e_w, e_g;
    if (!rst_n) begin
      chk("reset_outputs", ctl_vec(), 32'd0);
      m_active = 0; m_done = 0; m_pg = 0; m_n = 0; m_wr = 0; m_rd = 0;
      exp_q.delete();
    end else begin
      e_rdy = m_active && (m_wr <= m_n);
      e_w   = e_rdy && wr_valid;
      e_g   = m_active && rd_req && (m_rd < m_wr) && (m_rd <= m_n);
      chk("wr_ready", {31'd0, wr_ready}, {31'd0, e_rdy});
      chk("ram_w_en", {31'd0, ram_w_en}, {31'd0, e_w});
      chk("rd_gnt", {31'd0, rd_gnt}, {31'd0, e_g});
      chk("ram_r_en", {31'd0, ram_r_en}, {31'd0, e_g});
      chk("busy", {31'd0, busy}, {31'd0, m_active || m_done});
      chk("done", {31'd0, done}, {31'd0, m_done});
      chk("rd_valid", {31'd0, rd_valid}, {31'd0, m_pg});
      if (e_w) begin
        chk("ram_cnta", {28'd0, ram_cnta}, m_wr);
        chk("ram_b_in", ram_b_in, wr_data);
        exp_q.push_back(wr_data[HW-1:0]);
      end
      if (e_g) chk("ram_cntb", {28'd0, ram_cntb}, m_rd);
      m_pg = e_g;
      if (m_done) begin
        m_done = 0;
      end else if (!m_active) begin
        if (start) begin
          m_active = 1; m_n = int'(blk_num); m_wr = 0; m_rd = 0;
        end
      end else begin
        if (e_w) m_wr++;
        if (e_g) begin
          m_rd++;
          if (m_rd == m_n + 1) begin
            m_active = 0;
            m_done = 1;
          end
        end
      end
    end
  end

  // monitor: pop and compare returned read data
  always @(negedge clk) begin
    logic [HW-1:0] e;
    if (rst_n && rd_valid) begin
      if (exp_q.size() == 0) begin
        chk("rd_unexpected", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("rd_data", {20'd0, rd_data}, {20'd0, e});
      end
    end
  end

  // driver
  // wmode: 0 always valid, 1 random, 2 held low for 3 cycles then valid
  // rmode: 0 always request, 1 random
  task automatic run_pass(input int n, input int wmode, input int rmode,
                          input bit glitch, input int abort_at);
    int cyc;
    bit seen;
    @(posedge clk); #1;
    start = 1'b1; blk_num = CW'(n); wr_valid = 1'b0; rd_req = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0; seen = 0;
    while (!seen && cyc < 300) begin
      if (abort_at >= 0 && cyc == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk("async_reset", ctl_vec(), 32'd0);
        @(negedge clk); @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        wr_valid = 1'b0; rd_req = 1'b0;
        return;
      end
      case (wmode)
        0: wr_valid = 1'b1;
        1: wr_valid = 1'($urandom_range(0, 1));
        default: wr_valid = (cyc >= 3);
      endcase
      rd_req  = (rmode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      wr_data = DW'($urandom);
      if (glitch && cyc == 2) begin
        start = 1'b1; blk_num = CW'((n + 5) % NB);
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (done) seen = 1;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0; wr_valid = 1'b0; rd_req = 1'b0;
    if (!seen) chk("pass_timeout", 32'd1, 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    run_pass(3, 0, 0, 0, -1);         // back-to-back fill, reads trail by one
    run_pass(2, 2, 0, 0, -1);         // read requested before any write
    run_pass(15, 1, 1, 0, -1);        // full slot range, random valid
    run_pass(6, 0, 1, 1, -1);         // start during fill is ignored
    run_pass(5, 0, 1, 0, 2);          // reset after two writes
    run_pass(0, 0, 0, 0, -1);         // single-slot pass after reset
    for (int i = 0; i < 6; i++) begin
      run_pass(int'($urandom_range(0, NB - 1)), 1, 1, 0, -1);
    end
    repeat (4) @(posedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
